icache_ctrl_fsm: RTL and testbench

Sequencing control unit for the L1 instruction cache. It drives the memory-control selector (ReadSet / WriteLineAndTag / InvalidSet plus enable) and the set index. It orders lookups, miss handling toward L2, refills, and whole-cache flushes. It sits between the fetch-side request port, the hit/way-compare logic, the L2 port and the physical memory-control block.

---
 rtl/memory_pkg.sv | 29 ++
 rtl/icache_flush_cnt.sv | 29 ++
 rtl/icache_ctrl_fsm.sv | 161 ++++++++++++++++
 tb/tb_icache_ctrl_fsm.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// Shared memory-subsystem types: memory-control selector, L1 I-cache geometry
// and the I-cache control-unit state encoding.
package memory_pkg;

   localparam int ICACHE_L1_ASSOCIATIVITY = 4;
   localparam int ICACHE_L1_IDX_W         = 6;

   typedef enum logic [1:0] {
      ICACHE_READ_SET           = 2'd0,
      ICACHE_WRITE_LINE_AND_TAG = 2'd1,
      ICACHE_INVALID_SET        = 2'd2
   } icache_ctrl_e;

   typedef enum logic [2:0] {
      CU_INIT_FLUSH = 3'd0,
      CU_IDLE       = 3'd1,
      CU_LOOKUP     = 3'd2,
      CU_ANSWER     = 3'd3,
      CU_MISS_REQ   = 3'd4,
      CU_MISS_WAIT  = 3'd5,
      CU_REFILL     = 3'd6,
      CU_FLUSH      = 3'd7
   } icache_cu_state_e;

   function automatic logic is_sweep_state(input icache_cu_state_e s);
      return (s == CU_INIT_FLUSH) || (s == CU_FLUSH);
   endfunction

endpackage

// File: rtl/icache_flush_cnt.sv
// Wrapping set-index counter that walks every set during an invalidation sweep.
module icache_flush_cnt #(
   parameter int IDX_W = 6
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_clr,
   input  logic             i_en,
   output logic [IDX_W-1:0] o_cnt,
   output logic             o_last
);

   logic [IDX_W-1:0] r_cnt;

   // Sweep index register; wraps naturally after the last set.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= {IDX_W{1'b0}};
      end else if (i_clr) begin
         r_cnt <= {IDX_W{1'b0}};
      end else if (i_en) begin
         r_cnt <= r_cnt + {{(IDX_W-1){1'b0}}, 1'b1};
      end
   end

   assign o_cnt  = r_cnt;
   assign o_last = (r_cnt == {IDX_W{1'b1}});

endmodule

// File: rtl/icache_ctrl_fsm.sv
// L1 instruction-cache sequencer: lookups, L2 miss handling, refills and
// whole-cache invalidation sweeps, driving the memory-control selector.
module icache_ctrl_fsm
   import memory_pkg::*;
#(
   parameter int IDX_W = ICACHE_L1_IDX_W,
   parameter int N_WAY = ICACHE_L1_ASSOCIATIVITY
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             flush_i,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [IDX_W-1:0] req_idx_i,
   input  logic             hit_i,
   output logic             ans_valid_o,
   input  logic             ans_ready_i,
   output logic             l2_req_valid_o,
   input  logic             l2_req_ready_i,
   input  logic             l2_ans_valid_i,
   output icache_ctrl_e     cond_ctrl_o,
   output logic             mem_ctrl_en_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             repl_upd_o,
   output logic             flush_busy_o
);

   // A direct-mapped cache has no replacement state to advance.
   localparam logic REPL_ACTIVE = (N_WAY > 1) ? 1'b1 : 1'b0;

   icache_cu_state_e r_state, w_next_state;
   logic [IDX_W-1:0] r_idx;
   logic             r_flush_pend;
   logic             r_flush_busy;
   logic             r_armed;
   logic             w_idx_load, w_pend_set, w_pend_clr;
   logic             w_cnt_en, w_cnt_clr, w_cnt_last, w_repl_upd;
   logic [IDX_W-1:0] w_cnt;

   icache_flush_cnt #(.IDX_W(IDX_W)) u_flush_cnt (
      .i_clk   (clk_i),
      .i_rst_n (rst_n_i),
      .i_clr   (w_cnt_clr),
      .i_en    (w_cnt_en),
      .o_cnt   (w_cnt),
      .o_last  (w_cnt_last)
   );

   // State, idx latch, pending-flush bit and registered busy flag.
   // r_armed keeps every output quiet while reset is asserted.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state      <= CU_INIT_FLUSH;
         r_idx        <= {IDX_W{1'b0}};
         r_flush_pend <= 1'b0;
         r_flush_busy <= 1'b1;
         r_armed      <= 1'b0;
      end else begin
         r_state      <= w_next_state;
         r_flush_busy <= is_sweep_state(w_next_state);
         r_armed      <= 1'b1;
         if (w_idx_load) begin
            r_idx <= req_idx_i;
         end
         if (w_pend_clr) begin
            r_flush_pend <= 1'b0;
         end else if (w_pend_set) begin
            r_flush_pend <= 1'b1;
         end
      end
   end

   // Next-state and output decode.
   always_comb begin
      w_next_state   = r_state;
      req_ready_o    = 1'b0;
      ans_valid_o    = 1'b0;
      l2_req_valid_o = 1'b0;
      cond_ctrl_o    = ICACHE_READ_SET;
      mem_ctrl_en_o  = 1'b0;
      idx_o          = r_idx;
      w_repl_upd     = 1'b0;
      w_idx_load     = 1'b0;
      w_pend_set     = 1'b0;
      w_pend_clr     = 1'b0;
      w_cnt_en       = 1'b0;
      w_cnt_clr      = 1'b0;
      if (r_armed) begin
         case (r_state)
            CU_INIT_FLUSH, CU_FLUSH: begin
               cond_ctrl_o   = ICACHE_INVALID_SET;
               mem_ctrl_en_o = 1'b1;
               idx_o         = w_cnt;
               w_cnt_en      = 1'b1;
               if (w_cnt_last) begin
                  w_next_state = CU_IDLE;
               end else begin
                  w_next_state = r_state;
               end
            end
            CU_IDLE: begin
               w_cnt_clr = 1'b1;
               // A pending or fresh flush wins over any request.
               if (flush_i || r_flush_pend) begin
                  w_pend_clr   = 1'b1;
                  w_next_state = CU_FLUSH;
               end else begin
                  req_ready_o = 1'b1;
                  if (req_valid_i) begin
                     w_idx_load    = 1'b1;
                     mem_ctrl_en_o = 1'b1;
                     idx_o         = req_idx_i;
                     w_next_state  = CU_LOOKUP;
                  end else begin
                     w_next_state = CU_IDLE;
                  end
               end
            end
            CU_LOOKUP: begin
               w_pend_set   = flush_i;
               w_next_state = hit_i ? CU_ANSWER : CU_MISS_REQ;
            end
            CU_ANSWER: begin
               w_pend_set   = flush_i;
               ans_valid_o  = 1'b1;
               w_next_state = ans_ready_i ? CU_IDLE : CU_ANSWER;
            end
            CU_MISS_REQ: begin
               w_pend_set     = flush_i;
               l2_req_valid_o = 1'b1;
               w_next_state   = l2_req_ready_i ? CU_MISS_WAIT : CU_MISS_REQ;
            end
            CU_MISS_WAIT: begin
               w_pend_set = flush_i;
               if (l2_ans_valid_i) begin
                  cond_ctrl_o   = ICACHE_WRITE_LINE_AND_TAG;
                  mem_ctrl_en_o = 1'b1;
                  w_repl_upd    = 1'b1;
                  w_next_state  = CU_REFILL;
               end else begin
                  w_next_state = CU_MISS_WAIT;
               end
            end
            CU_REFILL: begin
               w_pend_set    = flush_i;
               mem_ctrl_en_o = 1'b1;
               w_next_state  = CU_LOOKUP;
            end
            default: begin
               w_next_state = CU_INIT_FLUSH;
            end
         endcase
      end else begin
         w_next_state = r_state;
      end
   end

   assign repl_upd_o   = w_repl_upd & REPL_ACTIVE;
   assign flush_busy_o = r_flush_busy;

endmodule

// File: tb/tb_icache_ctrl_fsm.sv
// Directed bench for icache_ctrl_fsm: memory operations are predicted into a
// queue as stimulus is applied and popped whenever the DUT enables the memories.
module tb_icache_ctrl_fsm;
   import memory_pkg::*;

   localparam int IDX_W  = ICACHE_L1_IDX_W;
   localparam int N_SETS = 1 << IDX_W;

   typedef struct packed {
      icache_ctrl_e     cond;
      logic [IDX_W-1:0] idx;
      logic             repl;
   } mem_op_t;

   logic             clk_i = 1'b0;
   logic             rst_n_i, flush_i, req_valid_i, req_ready_o, hit_i;
   logic [IDX_W-1:0] req_idx_i, idx_o;
   logic             ans_valid_o, ans_ready_i, l2_req_valid_o, l2_req_ready_i;
   logic             l2_ans_valid_i, mem_ctrl_en_o, repl_upd_o, flush_busy_o;
   icache_ctrl_e     cond_ctrl_o;

   mem_op_t exp_q[$];
   int n_pass  = 0;
   int n_total = 0;
   int n_fail  = 0;

   icache_ctrl_fsm #(.IDX_W(IDX_W), .N_WAY(ICACHE_L1_ASSOCIATIVITY)) dut (
      .clk_i          (clk_i),
      .rst_n_i        (rst_n_i),
      .flush_i        (flush_i),
      .req_valid_i    (req_valid_i),
      .req_ready_o    (req_ready_o),
      .req_idx_i      (req_idx_i),
      .hit_i          (hit_i),
      .ans_valid_o    (ans_valid_o),
      .ans_ready_i    (ans_ready_i),
      .l2_req_valid_o (l2_req_valid_o),
      .l2_req_ready_i (l2_req_ready_i),
      .l2_ans_valid_i (l2_ans_valid_i),
      .cond_ctrl_o    (cond_ctrl_o),
      .mem_ctrl_en_o  (mem_ctrl_en_o),
      .idx_o          (idx_o),
      .repl_upd_o     (repl_upd_o),
      .flush_busy_o   (flush_busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic push_op(input icache_ctrl_e c, input logic [IDX_W-1:0] i, input logic r);
      mem_op_t op;
      op.cond = c;
      op.idx  = i;
      op.repl = r;
      exp_q.push_back(op);
   endtask

   task automatic push_sweep();
      for (int k = 0; k < N_SETS; k++) push_op(ICACHE_INVALID_SET, IDX_W'(k), 1'b0);
   endtask

   // Compare the current cycle's memory operation against the scoreboard head.
   task automatic mon();
      mem_op_t obs, exp_op;
      if (mem_ctrl_en_o) begin
         obs.cond = cond_ctrl_o;
         obs.idx  = idx_o;
         obs.repl = repl_upd_o;
         if (exp_q.size() == 0) begin
            chk("mem_op_unexpected", 32'(mem_ctrl_en_o), 32'd0);
         end else begin
            exp_op = exp_q.pop_front();
            chk("mem_op", {23'd0, obs}, {23'd0, exp_op});
         end
      end
   endtask

   task automatic cyc();
      mon();
      @(posedge clk_i);
      #1;
   endtask

   // Run an invalidation sweep to completion, bounded in cycles.
   task automatic sweep_wait(input string tag);
      int  n_inv = 0;
      bit  done  = 1'b0;
      for (int c = 0; c < N_SETS + 8 && !done; c++) begin
         #1;
         if (!flush_busy_o) begin
            done = 1'b1;
         end else begin
            if (mem_ctrl_en_o && cond_ctrl_o == ICACHE_INVALID_SET) n_inv++;
            cyc();
         end
      end
      chk({tag, "_busy_low"}, 32'(flush_busy_o), 32'd0);
      chk({tag, "_sweep_len"}, 32'(n_inv), 32'(N_SETS));
      chk({tag, "_ready_after"}, 32'(req_ready_o), 32'd1);
      chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      rst_n_i = 1'b1; flush_i = 1'b0; req_valid_i = 1'b0; req_idx_i = '0;
      hit_i = 1'b0; ans_ready_i = 1'b0; l2_req_ready_i = 1'b0; l2_ans_valid_i = 1'b0;
      #1 rst_n_i = 1'b0;
      #1;
      chk("rst_busy", 32'(flush_busy_o), 32'd1);
      chk("rst_en", 32'(mem_ctrl_en_o), 32'd0);
      chk("rst_cond", 32'(cond_ctrl_o), 32'(ICACHE_READ_SET));
      chk("rst_idx", 32'(idx_o), 32'd0);
      chk("rst_ready", 32'(req_ready_o), 32'd0);
      chk("rst_ans", 32'(ans_valid_o), 32'd0);
      chk("rst_l2req", 32'(l2_req_valid_o), 32'd0);
      cyc();
      cyc();
      rst_n_i = 1'b1;
      push_sweep();
      sweep_wait("init");

      // Hit on 0x15 with a stalled answer
      req_valid_i = 1'b1; req_idx_i = 6'h15;
      push_op(ICACHE_READ_SET, 6'h15, 1'b0);
      #1 chk("hit_ready", 32'(req_ready_o), 32'd1);
      cyc();
      req_valid_i = 1'b0; hit_i = 1'b1;
      #1 chk("hit_lookup_no_ans", 32'(ans_valid_o), 32'd0);
      cyc();
      hit_i = 1'b0; ans_ready_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1 chk("hit_ans_hold", 32'(ans_valid_o), 32'd1);
         cyc();
      end
      ans_ready_i = 1'b1;
      #1 chk("hit_ans_hs", 32'(ans_valid_o), 32'd1);
      cyc();
      ans_ready_i = 1'b0;
      #1 chk("hit_ans_drop", 32'(ans_valid_o), 32'd0);
      chk("hit_idle_ready", 32'(req_ready_o), 32'd1);

      // Miss on 0x2A, L2 handshake delayed, stray L2 answer ignored
      req_valid_i = 1'b1; req_idx_i = 6'h2A;
      push_op(ICACHE_READ_SET, 6'h2A, 1'b0);
      #1 cyc();
      req_valid_i = 1'b0; hit_i = 1'b0;
      #1 cyc();
      l2_ans_valid_i = 1'b1;
      for (int k = 0; k < 2; k++) begin
         #1 chk("miss_l2req_hold", 32'(l2_req_valid_o), 32'd1);
         cyc();
      end
      l2_ans_valid_i = 1'b0; l2_req_ready_i = 1'b1;
      #1 chk("miss_l2req_hs", 32'(l2_req_valid_o), 32'd1);
      cyc();
      l2_req_ready_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1 chk("miss_wait_l2req", 32'(l2_req_valid_o), 32'd0);
         chk("miss_wait_en", 32'(mem_ctrl_en_o), 32'd0);
         cyc();
      end
      l2_ans_valid_i = 1'b1;
      push_op(ICACHE_WRITE_LINE_AND_TAG, 6'h2A, 1'b1);
      push_op(ICACHE_READ_SET, 6'h2A, 1'b0);
      #1 chk("miss_repl_upd", 32'(repl_upd_o), 32'd1);
      cyc();
      l2_ans_valid_i = 1'b0;
      #1 chk("miss_no_repl_replay", 32'(repl_upd_o), 32'd0);
      cyc();
      hit_i = 1'b1;
      #1 cyc();
      hit_i = 1'b0; ans_ready_i = 1'b1;
      #1 chk("miss_ans", 32'(ans_valid_o), 32'd1);
      cyc();
      ans_ready_i = 1'b0;
      #1 chk("miss_queue_empty", 32'(exp_q.size()), 32'd0);

      // Flush pulse while waiting on L2: miss completes, then full sweep
      req_valid_i = 1'b1; req_idx_i = 6'h07;
      push_op(ICACHE_READ_SET, 6'h07, 1'b0);
      #1 cyc();
      req_valid_i = 1'b0; hit_i = 1'b0;
      #1 cyc();
      l2_req_ready_i = 1'b1;
      #1 cyc();
      l2_req_ready_i = 1'b0; flush_i = 1'b1;
      #1 cyc();
      flush_i = 1'b0; l2_ans_valid_i = 1'b1;
      push_op(ICACHE_WRITE_LINE_AND_TAG, 6'h07, 1'b1);
      push_op(ICACHE_READ_SET, 6'h07, 1'b0);
      #1 cyc();
      l2_ans_valid_i = 1'b0;
      #1 cyc();
      hit_i = 1'b1;
      #1 cyc();
      hit_i = 1'b0; ans_ready_i = 1'b1;
      #1 chk("fpend_ans", 32'(ans_valid_o), 32'd1);
      cyc();
      ans_ready_i = 1'b0; req_valid_i = 1'b1; req_idx_i = 6'h3C;
      #1 chk("fpend_ready", 32'(req_ready_o), 32'd0);
      chk("fpend_no_accept", 32'(mem_ctrl_en_o), 32'd0);
      cyc();
      req_valid_i = 1'b0;
      push_sweep();
      sweep_wait("fpend");

      // Flush and request collide in IDLE
      req_valid_i = 1'b1; req_idx_i = 6'h11; flush_i = 1'b1;
      #1 chk("coll_ready", 32'(req_ready_o), 32'd0);
      chk("coll_no_accept", 32'(mem_ctrl_en_o), 32'd0);
      cyc();
      req_valid_i = 1'b0; flush_i = 1'b0;
      #1 chk("coll_sweep_ready", 32'(req_ready_o), 32'd0);
      chk("coll_sweep_busy", 32'(flush_busy_o), 32'd1);
      push_sweep();
      sweep_wait("coll");

      // Asynchronous reset while in REFILL
      req_valid_i = 1'b1; req_idx_i = 6'h33;
      push_op(ICACHE_READ_SET, 6'h33, 1'b0);
      #1 cyc();
      req_valid_i = 1'b0; hit_i = 1'b0;
      #1 cyc();
      l2_req_ready_i = 1'b1;
      #1 cyc();
      l2_req_ready_i = 1'b0; l2_ans_valid_i = 1'b1;
      push_op(ICACHE_WRITE_LINE_AND_TAG, 6'h33, 1'b1);
      #1 cyc();
      l2_ans_valid_i = 1'b0;
      #1 chk("refill_pre_en", 32'(mem_ctrl_en_o), 32'd1);
      rst_n_i = 1'b0;
      #1;
      chk("arst_en", 32'(mem_ctrl_en_o), 32'd0);
      chk("arst_cond", 32'(cond_ctrl_o), 32'(ICACHE_READ_SET));
      chk("arst_idx", 32'(idx_o), 32'd0);
      chk("arst_busy", 32'(flush_busy_o), 32'd1);
      chk("arst_repl", 32'(repl_upd_o), 32'd0);
      cyc();
      cyc();
      rst_n_i = 1'b1;
      push_sweep();
      sweep_wait("arst");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
